// File: rtl/data_memory_pkg.sv
// Shared definitions for the parameterised data memory: FSM state encoding
// and the default geometry/latency used when the top is instantiated bare.
package data_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_LATENCY    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of a counter able to hold LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that stops at zero and flags when it gets there.
module mem_latency_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/param_data_memory.sv
// Fixed-latency word memory with per-byte write enables and a
// busywait handshake. A request is captured once, completes LATENCY edges
// later, and a one-cycle DONE state prevents a held request re-triggering.
module param_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteen,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    busywait,
  output logic                    conflict
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = cnt_width(LATENCY);

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    capture_s;
  logic                    access_s;
  logic                    conflict_set_s;
  logic                    busywait_s;
  logic                    cnt_zero_s;
  logic [CNT_W-1:0]        cnt_value_s;

  logic                    op_write_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [LANES-1:0]        ben_r;
  logic [DATA_WIDTH-1:0]   readdata_r;
  logic                    conflict_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  mem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (capture_s),
    .load_value (CNT_W'(LATENCY - 1)),
    .dec        (state_r == BUSY),
    .count      (cnt_value_s),
    .zero       (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and handshake decode; busywait rises with the request itself.
  always_comb begin
    next_state_s   = state_r;
    capture_s      = 1'b0;
    access_s       = 1'b0;
    conflict_set_s = 1'b0;
    busywait_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (read ^ write) begin
          capture_s    = 1'b1;
          busywait_s   = 1'b1;
          next_state_s = BUSY;
        end else if (read && write) begin
          conflict_set_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        busywait_s = 1'b1;
        if (cnt_zero_s) begin
          access_s     = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Request capture; held values are what the access uses, not live inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_write_r <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      ben_r      <= {LANES{1'b0}};
    end else if (capture_s) begin
      op_write_r <= write;
      addr_r     <= address;
      wdata_r    <= writedata;
      ben_r      <= byteen;
    end else begin
      op_write_r <= op_write_r;
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
      ben_r      <= ben_r;
    end
  end

  // Storage with lane-masked write at the completion edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (access_s && op_write_r) begin
      for (int k = 0; k < LANES; k++) begin
        if (ben_r[k]) begin
          mem_r[addr_r][8*k +: 8] <= wdata_r[8*k +: 8];
        end
      end
    end
  end

  // Read result register: only a completed read changes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_r <= {DATA_WIDTH{1'b0}};
    end else if (access_s && !op_write_r) begin
      readdata_r <= mem_r[addr_r];
    end else begin
      readdata_r <= readdata_r;
    end
  end

  // Conflict flag, high for the cycle after an illegal read+write in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= conflict_set_s;
    end
  end

  assign readdata = readdata_r;
  assign conflict = conflict_r;
  assign busywait = busywait_s;

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits (multiple of 8, at least 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, meaning word-address width, so depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter LATENCY, default 5, meaning clock cycles from request capture to access completion (at least 1).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port read, input, 1 bit: read request, held by the requester until busywait falls.
REQ-007 The block SHALL have port write, input, 1 bit: write request, held by the requester until busywait falls.
REQ-008 The block SHALL have port address, input, ADDR_WIDTH bits: word address.
REQ-009 The block SHALL have port writedata, input, DATA_WIDTH bits: write word, byte lane k = bits [8k+7:8k].
REQ-010 The block SHALL have port byteen, input, DATA_WIDTH/8 bits: per-lane write enable, ignored on reads.
REQ-011 The block SHALL have port readdata, output, DATA_WIDTH bits: last completed read word.
REQ-012 The block SHALL have port busywait, output, 1 bit: requester stall.
REQ-013 The block SHALL have port conflict, output, 1 bit: one-cycle pulse flagging an illegal simultaneous read and write.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, each described in REQ-015 to REQ-020.
REQ-015 In IDLE, a rising edge with exactly one of read or write high SHALL capture op, address, writedata and byteen, load the counter with LATENCY-1, and enter BUSY.
REQ-016 In IDLE with read and write both high, the block SHALL perform no access, pulse conflict high for the following cycle, and stay in IDLE.
REQ-017 busywait SHALL equal (IDLE and exactly one of read or write high) or BUSY; it SHALL be combinational so it rises in the same cycle as the request.
REQ-018 In BUSY, the counter SHALL decrement each edge, and input changes SHALL be ignored because the captured values are used.
REQ-019 The edge at which the counter equals 0 in BUSY SHALL perform the access and enter DONE; the access completes on edge T0+LATENCY, where T0 is the capture edge.
REQ-020 A write SHALL update only the lanes with byteen[k]=1, and byteen=0 SHALL complete the handshake without changing memory.
REQ-021 A read SHALL load readdata with the full stored word at the completion edge, and readdata SHALL hold that value until the next read completes; a write SHALL leave readdata unchanged.
REQ-022 In DONE, busywait SHALL be 0, requests SHALL be ignored, and the block SHALL return to IDLE on the next edge, so a held request is never retriggered.
REQ-023 Back-to-back requests SHALL therefore cost LATENCY+2 edges each, measured from capture to the next possible capture.
REQ-024 Address arithmetic SHALL be word-indexed with no wrap or out-of-range case, because depth equals 2**ADDR_WIDTH.

Reset
REQ-025 Assertion of reset (low) SHALL immediately force IDLE, counter 0, readdata 0, conflict 0, busywait 0 (with read and write low), and all memory words to 0.
REQ-026 Reset during BUSY SHALL abort the pending access with no memory write and no readdata update.
REQ-027 The first request capture SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package data_memory_pkg SHALL hold the state enumeration (IDLE, BUSY, DONE) and the default parameter constants DATA_WIDTH, ADDR_WIDTH and LATENCY.
REQ-029 The down-counter with load and zero flag SHALL be the single sub-module mem_latency_counter, parametrised by width clog2(LATENCY).
REQ-030 Storage SHALL be one array of 2**ADDR_WIDTH words of DATA_WIDTH bits, with a per-lane masked write.

Verification
REQ-031 Defaults, write address 5, data 0xDEADBEEF, byteen 0xF, then read address 5 -> busywait high for 6 cycles each time, and readdata 0xDEADBEEF at the read completion edge.
REQ-032 Partial write of 0x11223344 with byteen 0x5 to address 5 (holding 0xDEADBEEF), then read -> readdata 0xDE22BE44.
REQ-033 read=write=1 in IDLE -> conflict pulses for 1 cycle, busywait 0, and memory and readdata unchanged.
REQ-034 Request held high through DONE -> exactly one access, and a new capture only on the edge after DONE.
REQ-035 Reset asserted 2 cycles into a write of 0xCAFEF00D to address 7 -> busywait 0 immediately, and a later read of address 7 returns 0.
REQ-036 Run with DATA_WIDTH=64, ADDR_WIDTH=4, LATENCY=1, byteen 0x80 write of 0xAB00000000000000 to address 15 -> read returns 0xAB00000000000000, with busywait high 2 cycles.
